// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file writeback path.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package arm_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 4;
  localparam int PC_REG_IDX = 15;

  // One candidate write to the register file.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Writes to R15 are diverted to the PC instead of the register file.
  function automatic logic is_pc_dest(input logic [ADDR_W-1:0] dest);
    return dest == ADDR_W'(PC_REG_IDX);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the pipeline writeback, aux handshake and register-file write port.
// Latency: n/a (wiring only).
// Backpressure: aux side uses aux_valid/aux_ready; pipe side is held by stall_pipe.
// Modports: master = pipeline/aux/regfile side, slave = the arbiter.
interface wb_port_arbiter_if;
  import arm_pkg::*;

  // pipeline writeback slot
  logic              pipe_valid;
  logic              pipe_wb_en;
  logic              pipe_mem_r_en;
  logic [ADDR_W-1:0] pipe_dest;
  logic [DATA_W-1:0] pipe_alu_res;
  logic [DATA_W-1:0] pipe_mem_data;
  // auxiliary (multiply) unit
  logic              aux_valid;
  logic              aux_ready;
  logic [ADDR_W-1:0] aux_dest;
  logic [DATA_W-1:0] aux_data;
  // control back to the pipeline
  logic              stall_pipe;
  // register-file write port and PC diversion
  logic              writeBackEn;
  logic [ADDR_W-1:0] Dest_wb;
  logic [DATA_W-1:0] Result_WB;
  logic              pc_wr;
  logic [DATA_W-1:0] pc_val;
  // pending-write info for hazard/forwarding
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_dest;

  modport master (
    output pipe_valid, pipe_wb_en, pipe_mem_r_en, pipe_dest, pipe_alu_res, pipe_mem_data,
    output aux_valid, aux_dest, aux_data,
    input  aux_ready, stall_pipe, writeBackEn, Dest_wb, Result_WB, pc_wr, pc_val,
    input  pend_valid, pend_dest
  );

  modport slave (
    input  pipe_valid, pipe_wb_en, pipe_mem_r_en, pipe_dest, pipe_alu_res, pipe_mem_data,
    input  aux_valid, aux_dest, aux_data,
    output aux_ready, stall_pipe, writeBackEn, Dest_wb, Result_WB, pc_wr, pc_val,
    output pend_valid, pend_dest
  );

endinterface

// File: rtl/wb_hold_buf.sv
// One-entry holding buffer for aux results awaiting a register-file slot.
// Latency: captured at the accepting posedge, visible on full/dest/data the cycle after.
// Backpressure: in_ready == !full, so a full buffer never accepts, even on the draining cycle.
// Ports: clk, rst (sync, active-low); in_valid/in_ready/in_dest/in_data; pop; full/dest/data.
module wb_hold_buf
  import arm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_data,
  input  logic              pop,
  output logic              full,
  output logic [ADDR_W-1:0] dest,
  output logic [DATA_W-1:0] data
);

  assign in_ready = !full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      full <= 1'b0;
      dest <= '0;
      data <= '0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      dest <= in_dest;
      data <= in_data;
    end else if (pop) begin
      // dest/data are left as-is; only full qualifies them
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the pipeline (priority) and a buffered aux unit.
// Latency: 1 cycle from grant to writeBackEn/Dest_wb/Result_WB (or pc_wr/pc_val for R15).
// Backpressure: aux held via aux_ready; pipe stalled one cycle once aux is denied STARVE_LIMIT times.
// Ports: clk, rst (sync, active-low), bus (wb_port_arbiter_if.slave).
// CNT_W must satisfy 2**CNT_W > STARVE_LIMIT so the saturated count is representable.
module wb_port_arbiter
  import arm_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_port_arbiter_if.slave     bus
);

  logic              buf_full;
  logic [ADDR_W-1:0] buf_dest;
  logic [DATA_W-1:0] buf_data;
  logic              buf_pop;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              pipe_req;
  wb_req_t           grant;

  wb_hold_buf u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.aux_valid),
    .in_ready (bus.aux_ready),
    .in_dest  (bus.aux_dest),
    .in_data  (bus.aux_data),
    .pop      (buf_pop),
    .full     (buf_full),
    .dest     (buf_dest),
    .data     (buf_data)
  );

  assign bus.pend_valid = buf_full;
  assign bus.pend_dest  = buf_dest;

  // Stall only depends on registered state, so it never loops back through pipe inputs.
  assign bus.stall_pipe = buf_full && (cnt == CNT_W'(STARVE_LIMIT));
  assign pipe_req       = bus.pipe_valid && bus.pipe_wb_en && !bus.stall_pipe;

  always_comb begin
    grant   = '0;
    buf_pop = 1'b0;
    cnt_nxt = cnt;
    if (pipe_req) begin
      grant.en   = 1'b1;
      grant.dest = bus.pipe_dest;
      grant.data = bus.pipe_mem_r_en ? bus.pipe_mem_data : bus.pipe_alu_res;
      // each pipe win while aux waits counts as one denial
      if (buf_full && (cnt != CNT_W'(STARVE_LIMIT))) begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end else if (buf_full) begin
      grant.en   = 1'b1;
      grant.dest = buf_dest;
      grant.data = buf_data;
      buf_pop    = 1'b1;
      cnt_nxt    = '0;
    end
  end

  // Every output register is rewritten each cycle, so enables are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt             <= '0;
      bus.writeBackEn <= 1'b0;
      bus.Dest_wb     <= '0;
      bus.Result_WB   <= '0;
      bus.pc_wr       <= 1'b0;
      bus.pc_val      <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (grant.en && !is_pc_dest(grant.dest)) begin
        bus.writeBackEn <= 1'b1;
        bus.Dest_wb     <= grant.dest;
        bus.Result_WB   <= grant.data;
      end else begin
        bus.writeBackEn <= 1'b0;
        bus.Dest_wb     <= '0;
        bus.Result_WB   <= '0;
      end
      if (grant.en && is_pc_dest(grant.dest)) begin
        bus.pc_wr  <= 1'b1;
        bus.pc_val <= grant.data;
      end else begin
        bus.pc_wr  <= 1'b0;
        bus.pc_val <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a transaction-level model checked every cycle.
// Latency: model predicts the committed write one cycle after each grant.
// Backpressure: stimulus re-presents a pipe write whenever stall_pipe was high.
module tb_wb_port_arbiter;
  import arm_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // State: at most one pending aux write plus how many cycles it has been passed over.
  bit          m_pend = 1'b0;
  logic [3:0]  m_pdest = '0;
  logic [31:0] m_pdata = '0;
  int          m_denied = 0;
  bit          e_we = 1'b0, e_pc = 1'b0;
  logic [3:0]  e_dest = '0;
  logic [31:0] e_res = '0, e_pcv = '0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    bit          stall, preq, take, won;
    logic [3:0]  wd;
    logic [31:0] wv;
    won = 1'b0; wd = '0; wv = '0;
    if (!rst) begin
      m_pend = 1'b0; m_denied = 0; m_pdest = '0; m_pdata = '0;
      e_we = 1'b0; e_pc = 1'b0; e_dest = '0; e_res = '0; e_pcv = '0;
    end else begin
      stall = m_pend && (m_denied >= LIMIT);
      preq  = bus.pipe_valid && bus.pipe_wb_en && !stall;
      take  = bus.aux_valid && !m_pend;
      if (preq) begin
        won = 1'b1; wd = bus.pipe_dest;
        wv  = bus.pipe_mem_r_en ? bus.pipe_mem_data : bus.pipe_alu_res;
        if (m_pend) m_denied++;
      end else if (m_pend) begin
        won = 1'b1; wd = m_pdest; wv = m_pdata;
        m_pend = 1'b0; m_denied = 0;
      end
      if (take) begin
        m_pend = 1'b1; m_pdest = bus.aux_dest; m_pdata = bus.aux_data; m_denied = 0;
      end
      e_we = won && (wd != 4'd15); e_dest = wd; e_res = wv;
      e_pc = won && (wd == 4'd15); e_pcv = wv;
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("aux_ready",   32'(bus.aux_ready),   32'(!m_pend));
      chk("stall_pipe",  32'(bus.stall_pipe),  32'(m_pend && (m_denied >= LIMIT)));
      chk("pend_valid",  32'(bus.pend_valid),  32'(m_pend));
      chk("writeBackEn", 32'(bus.writeBackEn), 32'(e_we));
      chk("pc_wr",       32'(bus.pc_wr),       32'(e_pc));
      if (m_pend) chk("pend_dest", 32'(bus.pend_dest), 32'(m_pdest));
      if (e_we) begin
        chk("Dest_wb",   32'(bus.Dest_wb),   32'(e_dest));
        chk("Result_WB", 32'(bus.Result_WB), e_res);
      end
      if (e_pc) chk("pc_val", bus.pc_val, e_pcv);
    end
  end

  // register file stand-in, written on the negedge of the commit cycle
  logic [31:0] rf [0:14];
  bit          r9_written = 1'b0;
  initial for (int i = 0; i < 15; i++) rf[i] = '0;
  always @(negedge clk) begin
    if (bus.writeBackEn && (bus.Dest_wb != 4'd15)) begin
      rf[bus.Dest_wb] = bus.Result_WB;
      if (bus.Dest_wb == 4'd9) r9_written = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pipe_set(input bit v, input logic [3:0] d, input logic [31:0] alu,
                          input bit ld, input logic [31:0] mem);
    bus.pipe_valid = v; bus.pipe_wb_en = v; bus.pipe_dest = d;
    bus.pipe_alu_res = alu; bus.pipe_mem_r_en = ld; bus.pipe_mem_data = mem;
  endtask

  task automatic aux_set(input bit v, input logic [3:0] d, input logic [31:0] x);
    bus.aux_valid = v; bus.aux_dest = d; bus.aux_data = x;
  endtask

  initial begin
    logic [3:0] exp_seq [7];
    logic [3:0] commits [$];
    int k, stalls;
    bit st;
    exp_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd6};

    pipe_set(0, 0, 0, 0, 0);
    aux_set(0, 0, 0);

    // reset, then idle
    rst = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b1;
    chk("rst_writeBackEn", 32'(bus.writeBackEn), 32'd0);
    chk("rst_Dest_wb",     32'(bus.Dest_wb),     32'd0);
    chk("rst_Result_WB",   bus.Result_WB,        32'd0);
    chk("rst_pc_wr",       32'(bus.pc_wr),       32'd0);
    chk("rst_pc_val",      bus.pc_val,           32'd0);
    chk("rst_pend_valid",  32'(bus.pend_valid),  32'd0);
    chk("rst_pend_dest",   32'(bus.pend_dest),   32'd0);
    chk("rst_aux_ready",   32'(bus.aux_ready),   32'd1);
    chk("rst_stall_pipe",  32'(bus.stall_pipe),  32'd0);
    tick();

    // pipe-only ALU then load
    pipe_set(1, 4'd3, 32'h11, 0, 32'h0);
    tick();
    chk("alu_we",   32'(bus.writeBackEn), 32'd1);
    chk("alu_dest", 32'(bus.Dest_wb),     32'd3);
    chk("alu_res",  bus.Result_WB,        32'h11);
    pipe_set(1, 4'd4, 32'h55, 1, 32'hABCD);
    tick();
    chk("ld_we",   32'(bus.writeBackEn), 32'd1);
    chk("ld_dest", 32'(bus.Dest_wb),     32'd4);
    chk("ld_res",  bus.Result_WB,        32'hABCD);
    pipe_set(0, 0, 0, 0, 0);
    tick(); tick();
    chk("rf_r3", rf[3], 32'h11);
    chk("rf_r4", rf[4], 32'hABCD);

    // aux into a free slot
    aux_set(1, 4'd7, 32'hDEAD);
    tick();
    aux_set(0, 0, 0);
    chk("aux_pend_valid", 32'(bus.pend_valid), 32'd1);
    chk("aux_pend_dest",  32'(bus.pend_dest),  32'd7);
    chk("aux_ready_full", 32'(bus.aux_ready),  32'd0);
    chk("aux_no_wb_yet",  32'(bus.writeBackEn), 32'd0);
    tick();
    chk("aux_we",    32'(bus.writeBackEn), 32'd1);
    chk("aux_dest",  32'(bus.Dest_wb),     32'd7);
    chk("aux_res",   bus.Result_WB,        32'hDEAD);
    chk("aux_ready_back", 32'(bus.aux_ready), 32'd1);
    tick();
    chk("rf_r7", rf[7], 32'hDEAD);

    // starvation: aux waits while pipe writes every cycle
    aux_set(1, 4'd8, 32'hA5A5);
    k = 0; stalls = 0;
    for (int c = 0; c < 20 && k < 6; c++) begin
      pipe_set(1, 4'(k + 1), 32'h100 + 32'(k), 0, 0);
      st = bus.stall_pipe;
      if (st) stalls++;
      tick();
      aux_set(0, 0, 0);
      if (!st) k++;
      if (bus.writeBackEn) commits.push_back(bus.Dest_wb);
    end
    if (k < 6) begin
      n_checks++; n_fail++;
      $display("FAIL starve_timeout: pipe items accepted %0d, expected 6", k);
    end
    pipe_set(0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      if (bus.writeBackEn) commits.push_back(bus.Dest_wb);
    end
    chk("starve_stalls", 32'(stalls), 32'd1);
    chk("starve_ncommit", 32'(commits.size()), 32'd7);
    for (int i = 0; i < 7 && i < commits.size(); i++)
      chk($sformatf("starve_order[%0d]", i), 32'(commits[i]), 32'(exp_seq[i]));
    chk("rf_r8", rf[8], 32'hA5A5);

    // R15 diversion
    pipe_set(1, 4'd15, 32'h100, 0, 0);
    tick();
    pipe_set(0, 0, 0, 0, 0);
    chk("pc_wr",     32'(bus.pc_wr),       32'd1);
    chk("pc_val",    bus.pc_val,           32'h100);
    chk("pc_no_we",  32'(bus.writeBackEn), 32'd0);
    tick();
    chk("pc_pulse",  32'(bus.pc_wr),       32'd0);

    // reset while an aux write is pending (pipe busy so it cannot drain)
    pipe_set(1, 4'd2, 32'h22, 0, 0);
    aux_set(1, 4'd9, 32'h99);
    tick();
    aux_set(1, 4'd10, 32'h1010);
    tick();
    chk("hold_pend_dest", 32'(bus.pend_dest), 32'd9);
    chk("hold_aux_ready", 32'(bus.aux_ready), 32'd0);
    rst = 1'b0;
    aux_set(0, 0, 0);
    pipe_set(0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    chk("mid_rst_pend", 32'(bus.pend_valid),  32'd0);
    chk("mid_rst_we",   32'(bus.writeBackEn), 32'd0);
    tick(); tick(); tick();
    chk("r9_never_written", 32'(r9_written), 32'd0);
    chk("rf_r9", rf[9], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
